// File: rtl/instruction_decode_hz.sv
// LEGv8 ID stage: register file with WB bypass, control decode, sign extension, and the ID/EX register.
// It also handles load-use stalls and flushes. Define ID_STALL_CNT_EN to add the stall_cnt output.
module instruction_decode_hz #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32,
  parameter int PC_W   = 64
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic              regwrite_wb,
  input  logic [4:0]        rd_wb,
  input  logic [DATA_W-1:0] wbdata,
  input  logic [31:0]       instruction_id,
  input  logic [PC_W-1:0]   pc_id,
  input  logic              valid_id,
  input  logic              flush,
  output logic              stall_id,
  output logic              valid_ex,
  output logic              RegWrite_EX,
  output logic              ALUSrc_EX,
  output logic              Branch_EX,
  output logic              Uncondbranch_EX,
  output logic              MemRead_EX,
  output logic              MemWrite_EX,
  output logic              Mem2Reg_EX,
  output logic [3:0]        ALUOp_EX,
  output logic [4:0]        RD_EX,
  output logic [DATA_W-1:0] RegOutA_EX,
  output logic [DATA_W-1:0] RegOutB_EX,
  output logic [DATA_W-1:0] SignExtImm64_EX,
  output logic [PC_W-1:0]   pc_EX,
  output logic              illegal_EX
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam logic [4:0] XZR = 5'(NREG-1);

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       branch;
    logic       uncond;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic [3:0] alu_op;
  } ctl_t;

  logic [DATA_W-1:0] rf [NREG];
  ctl_t              ctl, ctl_ex;
  logic [DATA_W-1:0] imm, opa, opb;
  logic              reads_b, use_rt, illegal, hazard, load;
  logic [4:0]        rn, b_idx;
  logic [10:0]       opc;

  assign opc   = instruction_id[31:21];
  assign rn    = instruction_id[9:5];
  assign b_idx = use_rt ? instruction_id[4:0] : instruction_id[20:16];

  always_comb begin
    ctl     = '0;
    imm     = '0;
    reads_b = 1'b0;
    use_rt  = 1'b0;
    illegal = 1'b0;
    casez (opc)
      11'h7C2: begin
        ctl.mem_read = 1'b1; ctl.mem2reg = 1'b1; ctl.alu_src = 1'b1;
        ctl.reg_write = 1'b1; ctl.alu_op = 4'b0010;
        imm = {{(DATA_W-9){instruction_id[20]}}, instruction_id[20:12]};
      end
      11'h7C0: begin
        ctl.mem_write = 1'b1; ctl.alu_src = 1'b1; ctl.alu_op = 4'b0010;
        imm = {{(DATA_W-9){instruction_id[20]}}, instruction_id[20:12]};
        reads_b = 1'b1; use_rt = 1'b1;
      end
      11'h458: begin ctl.reg_write = 1'b1; ctl.alu_op = 4'b0010; reads_b = 1'b1; end
      11'h658: begin ctl.reg_write = 1'b1; ctl.alu_op = 4'b0110; reads_b = 1'b1; end
      11'h450: begin ctl.reg_write = 1'b1; ctl.alu_op = 4'b0000; reads_b = 1'b1; end
      11'h550: begin ctl.reg_write = 1'b1; ctl.alu_op = 4'b0001; reads_b = 1'b1; end
      11'b10110100_???: begin
        ctl.branch = 1'b1; ctl.alu_op = 4'b0111;
        imm = {{(DATA_W-19){instruction_id[23]}}, instruction_id[23:5]};
        reads_b = 1'b1; use_rt = 1'b1;
      end
      11'b000101_?????: begin
        ctl.uncond = 1'b1;
        imm = {{(DATA_W-26){instruction_id[25]}}, instruction_id[25:0]};
      end
      default: illegal = 1'b1;
    endcase
  end

  // XZR and out-of-range indices read as zero; a same-cycle write-back wins over the array
  function automatic logic [DATA_W-1:0] rd_reg(input logic [4:0] idx);
    if (int'(idx) >= NREG || idx == XZR) return '0;
    if (regwrite_wb && rd_wb == idx)     return wbdata;
    return rf[idx];
  endfunction

  assign opa = rd_reg(rn);
  assign opb = reads_b ? rd_reg(b_idx) : '0;

  assign hazard   = valid_ex & MemRead_EX & (RD_EX != XZR) & valid_id &
                    ((RD_EX == rn) | (reads_b & (RD_EX == b_idx)));
  assign stall_id = hazard & ~flush;
  assign load     = valid_id & ~flush & ~stall_id;

  always_ff @(posedge clk) begin
    if (resetl) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (regwrite_wb && rd_wb != XZR && int'(rd_wb) < NREG) begin
      rf[rd_wb] <= wbdata;
    end
  end

  // Bubbles clear the data fields too, so EX never sees stale operands
  always_ff @(posedge clk) begin
    if (resetl || !load) begin
      valid_ex        <= 1'b0;
      ctl_ex          <= '0;
      RD_EX           <= '0;
      RegOutA_EX      <= '0;
      RegOutB_EX      <= '0;
      SignExtImm64_EX <= '0;
      pc_EX           <= '0;
      illegal_EX      <= 1'b0;
    end else begin
      valid_ex        <= 1'b1;
      ctl_ex          <= ctl;
      RD_EX           <= instruction_id[4:0];
      RegOutA_EX      <= opa;
      RegOutB_EX      <= opb;
      SignExtImm64_EX <= imm;
      pc_EX           <= pc_id;
      illegal_EX      <= illegal;
    end
  end

  assign RegWrite_EX     = ctl_ex.reg_write;
  assign ALUSrc_EX       = ctl_ex.alu_src;
  assign Branch_EX       = ctl_ex.branch;
  assign Uncondbranch_EX = ctl_ex.uncond;
  assign MemRead_EX      = ctl_ex.mem_read;
  assign MemWrite_EX     = ctl_ex.mem_write;
  assign Mem2Reg_EX      = ctl_ex.mem2reg;
  assign ALUOp_EX        = ctl_ex.alu_op;

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (resetl)                              stall_cnt <= '0;
    else if (stall_id && stall_cnt != '1)    stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_instruction_decode_hz.sv
// Directed-vector scoreboard bench for instruction_decode_hz.
module tb_instruction_decode_hz;
  logic        clk = 1'b0;
  logic        resetl, regwrite_wb, valid_id, flush;
  logic [4:0]  rd_wb;
  logic [63:0] wbdata, pc_id;
  logic [31:0] instruction_id;
  logic        stall_id, valid_ex, RegWrite_EX, ALUSrc_EX, Branch_EX, Uncondbranch_EX;
  logic        MemRead_EX, MemWrite_EX, Mem2Reg_EX, illegal_EX;
  logic [3:0]  ALUOp_EX;
  logic [4:0]  RD_EX;
  logic [63:0] RegOutA_EX, RegOutB_EX, SignExtImm64_EX, pc_EX;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  instruction_decode_hz dut (
    .clk(clk), .resetl(resetl), .regwrite_wb(regwrite_wb), .rd_wb(rd_wb), .wbdata(wbdata),
    .instruction_id(instruction_id), .pc_id(pc_id), .valid_id(valid_id), .flush(flush),
    .stall_id(stall_id), .valid_ex(valid_ex), .RegWrite_EX(RegWrite_EX), .ALUSrc_EX(ALUSrc_EX),
    .Branch_EX(Branch_EX), .Uncondbranch_EX(Uncondbranch_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .Mem2Reg_EX(Mem2Reg_EX), .ALUOp_EX(ALUOp_EX), .RD_EX(RD_EX),
    .RegOutA_EX(RegOutA_EX), .RegOutB_EX(RegOutB_EX), .SignExtImm64_EX(SignExtImm64_EX),
    .pc_EX(pc_EX), .illegal_EX(illegal_EX)
`ifdef ID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic        chk_stall;
    logic        stall;
    logic        v;
    logic [6:0]  c;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [63:0] a, b, imm, pc;
    logic        ill;
  } exp_t;

  // {RegWrite, ALUSrc, Branch, Uncondbranch, MemRead, MemWrite, Mem2Reg}
  localparam logic [6:0] C_LD = 7'b1100101, C_ST = 7'b0100010, C_R = 7'b1000000;
  localparam logic [6:0] C_CB = 7'b0010000, C_B = 7'b0001000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic [31:0] LDUR9  = 32'hF84003E9;
  localparam logic [31:0] ORR10  = 32'hAA1F012A;
  localparam logic [31:0] ADD11  = {11'h458, 5'd2, 6'd0, 5'd9, 5'd11};
  localparam logic [31:0] ORR12Z = {11'h550, 5'd31, 6'd0, 5'd31, 5'd12};
  localparam logic [31:0] CBZ9   = {8'hB4, 19'h7FFFF, 5'd9};
  localparam logic [31:0] STUR9  = {11'h7C0, 9'h1FF, 2'b00, 5'd10, 5'd9};
  localparam logic [31:0] SUB13  = {11'h658, 5'd9, 6'd0, 5'd9, 5'd13};
  localparam logic [31:0] AND14  = {11'h450, 5'd9, 6'd0, 5'd9, 5'd14};
  localparam logic [31:0] BNEG   = {6'h05, 26'h2000000};
  localparam logic [31:0] ADD15  = {11'h458, 5'd9, 6'd0, 5'd3, 5'd15};
  localparam logic [31:0] LDUR31 = {11'h7C2, 9'd0, 2'b00, 5'd31, 5'd31};

  exp_t q[$];
  int total = 0, bad = 0;

  function automatic exp_t ex(string n, logic v, logic [6:0] c, logic [3:0] op, logic [4:0] rd,
                              logic [63:0] a, logic [63:0] b, logic [63:0] imm, logic [63:0] pc,
                              logic ill);
    exp_t e;
    e.name = n; e.chk_stall = 1'b1; e.stall = 1'b0; e.v = v; e.c = c; e.op = op; e.rd = rd;
    e.a = a; e.b = b; e.imm = imm; e.pc = pc; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t bub(string n);
    return ex(n, 1'b0, 7'd0, 4'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
  endfunction

  task automatic step(input logic rs, input logic [31:0] ins, input logic [63:0] pc,
                      input logic vid, input logic fl, input logic we, input logic [4:0] rdw,
                      input logic [63:0] wd, input logic cs, input logic st, input exp_t e);
    resetl = rs; instruction_id = ins; pc_id = pc; valid_id = vid; flush = fl;
    regwrite_wb = we; rd_wb = rdw; wbdata = wd;
    e.chk_stall = cs; e.stall = st;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: stall_id is sampled mid-cycle, EX outputs just after the following edge
  initial begin
    exp_t r;
    logic s;
    logic [273:0] got, want;
    forever begin
      @(negedge clk);
      s = stall_id;
      @(posedge clk); #2;
      if (q.size() > 0) begin
        r = q.pop_front();
        if (r.chk_stall) begin
          total++;
          if (s !== r.stall) begin
            bad++;
            $display("FAIL stall_%s: got %b want %b", r.name, s, r.stall);
          end
        end
        got  = {valid_ex, RegWrite_EX, ALUSrc_EX, Branch_EX, Uncondbranch_EX, MemRead_EX,
                MemWrite_EX, Mem2Reg_EX, ALUOp_EX, RD_EX, RegOutA_EX, RegOutB_EX,
                SignExtImm64_EX, pc_EX, illegal_EX};
        want = {r.v, r.c, r.op, r.rd, r.a, r.b, r.imm, r.pc, r.ill};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL ex_%s: got %h want %h", r.name, got, want);
        end
      end
    end
  end

  initial begin
    resetl = 1'b1; instruction_id = '0; pc_id = '0; valid_id = 1'b0; flush = 1'b0;
    regwrite_wb = 1'b0; rd_wb = '0; wbdata = '0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, bub("rst0"));
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, bub("rst1"));
    step(0, LDUR9, 64'h4, 1, 0, 0, 0, 0, 1, 0,
         ex("ldur", 1, C_LD, 4'b0010, 5'd9, 0, 0, 0, 64'h4, 0));
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, bub("novalid"));
    step(0, ORR10, 64'h8, 1, 0, 1, 5'd9, 64'h1234, 1, 0,
         ex("orr_bypass", 1, C_R, 4'b0001, 5'd10, 64'h1234, 0, 0, 64'h8, 0));
    step(0, LDUR9, 64'hC, 1, 0, 0, 0, 0, 1, 0,
         ex("ldur2", 1, C_LD, 4'b0010, 5'd9, 0, 0, 0, 64'hC, 0));
    step(0, ADD11, 64'h10, 1, 0, 0, 0, 0, 1, 1, bub("loaduse_rn"));
    step(0, ADD11, 64'h10, 1, 0, 0, 0, 0, 1, 0,
         ex("add_after", 1, C_R, 4'b0010, 5'd11, 64'h1234, 0, 0, 64'h10, 0));
    step(0, LDUR9, 64'h14, 1, 0, 0, 0, 0, 1, 0,
         ex("ldur3", 1, C_LD, 4'b0010, 5'd9, 0, 0, 0, 64'h14, 0));
    step(0, ADD11, 64'h18, 1, 1, 1, 5'd31, 64'hFF, 1, 0, bub("flush"));
    step(0, ORR12Z, 64'h1C, 1, 0, 0, 0, 0, 1, 0,
         ex("xzr_read", 1, C_R, 4'b0001, 5'd12, 0, 0, 0, 64'h1C, 0));
    step(0, CBZ9, 64'h20, 1, 0, 0, 0, 0, 1, 0,
         ex("cbz", 1, C_CB, 4'b0111, 5'd9, 0, 64'h1234, ONES, 64'h20, 0));
    step(0, 32'h0, 64'h24, 1, 0, 0, 0, 0, 1, 0,
         ex("illegal", 1, 7'd0, 4'd0, 5'd0, 0, 0, 0, 64'h24, 1));
    step(0, STUR9, 64'h28, 1, 0, 0, 0, 0, 1, 0,
         ex("stur", 1, C_ST, 4'b0010, 5'd9, 0, 64'h1234, ONES, 64'h28, 0));
    step(0, SUB13, 64'h2C, 1, 0, 1, 5'd9, 64'hABCD, 1, 0,
         ex("sub_bypass", 1, C_R, 4'b0110, 5'd13, 64'hABCD, 64'hABCD, 0, 64'h2C, 0));
    step(0, AND14, 64'h30, 1, 0, 0, 0, 0, 1, 0,
         ex("and", 1, C_R, 4'b0000, 5'd14, 64'hABCD, 64'hABCD, 0, 64'h30, 0));
    step(0, BNEG, 64'h34, 1, 0, 0, 0, 0, 1, 0,
         ex("b_neg", 1, C_B, 4'b0000, 5'd0, 0, 0, 64'hFFFF_FFFF_FE00_0000, 64'h34, 0));
    step(0, LDUR9, 64'h38, 1, 0, 0, 0, 0, 1, 0,
         ex("ldur4", 1, C_LD, 4'b0010, 5'd9, 0, 0, 0, 64'h38, 0));
    step(0, STUR9, 64'h3C, 1, 0, 0, 0, 0, 1, 1, bub("loaduse_rt"));
    step(0, STUR9, 64'h3C, 1, 0, 0, 0, 0, 1, 0,
         ex("stur_after", 1, C_ST, 4'b0010, 5'd9, 0, 64'hABCD, ONES, 64'h3C, 0));
    step(0, LDUR9, 64'h40, 1, 0, 0, 0, 0, 1, 0,
         ex("ldur5", 1, C_LD, 4'b0010, 5'd9, 0, 0, 0, 64'h40, 0));
    step(0, ADD15, 64'h44, 1, 0, 0, 0, 0, 1, 1, bub("loaduse_rm"));
`ifdef ID_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd3) begin bad++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
`endif
    step(0, ADD15, 64'h44, 1, 0, 0, 0, 0, 1, 0,
         ex("add15", 1, C_R, 4'b0010, 5'd15, 0, 64'hABCD, 0, 64'h44, 0));
    step(1, ORR10, 64'h8, 1, 0, 1, 5'd9, 64'h55, 1, 0, bub("mid_reset"));
`ifdef ID_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stall_cnt_rst: got %0d want 0", stall_cnt); end
`endif
    step(0, ORR10, 64'h8, 1, 0, 0, 0, 0, 1, 0,
         ex("rf_cleared", 1, C_R, 4'b0001, 5'd10, 0, 0, 0, 64'h8, 0));
    step(0, LDUR31, 64'h48, 1, 0, 0, 0, 0, 1, 0,
         ex("ldur_xzr", 1, C_LD, 4'b0010, 5'd31, 0, 0, 0, 64'h48, 0));
    step(0, ORR12Z, 64'h4C, 1, 0, 0, 0, 0, 1, 0,
         ex("no_stall_xzr", 1, C_R, 4'b0001, 5'd12, 0, 0, 0, 64'h4C, 0));
    valid_id = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_decode_hz.md
Name: instruction_decode_hz

Overview:
Parametrised ID stage for the LEGv8 five-stage pipeline, replacing the fixed 64-bit decode stage.
- Contains the register file, main control decode, sign extension, and the ID/EX pipeline register.
- Adds write-back bypass, load-use hazard detection with stall/bubble insertion, flush from branch resolution, and a valid bit through EX.
- Sits between the IF/ID register and the execute stage.

Parameters:
DATA_W  64  register/bus data width; immediates sign-extend to this width
NREG    32  register count; index NREG-1 is XZR (reads 0, writes ignored)
PC_W    64  program counter width

Ports:
clk                  input   1          rising-edge clock
resetl               input   1          reset
regwrite_wb          input   1          write-back enable
rd_wb                input   5          write-back destination register
wbdata               input   DATA_W     write-back data
instruction_id       input   32         instruction in ID
pc_id                input   PC_W       PC of instruction in ID
valid_id             input   1          ID slot holds a real instruction
flush                input   1          branch taken in MEM; kill the ID/EX contents
stall_id             output  1          hold PC and IF/ID this cycle (combinational)
valid_ex             output  1          EX slot valid
RegWrite_EX, ALUSrc_EX, Branch_EX, Uncondbranch_EX, MemRead_EX, MemWrite_EX, Mem2Reg_EX  output  1 each  registered controls
ALUOp_EX             output  4          registered ALU operation
RD_EX                output  5          registered destination (Rd/Rt)
RegOutA_EX           output  DATA_W     registered Rn value
RegOutB_EX           output  DATA_W     registered Rm value (Rt for STUR/CBZ)
SignExtImm64_EX      output  DATA_W     registered sign-extended immediate
pc_EX                output  PC_W       registered PC
illegal_EX           output  1          registered unknown-opcode flag

Behaviour:
- Reset: one clock, synchronous, active-high on resetl.
  - On the reset edge every _EX output, valid_ex and illegal_EX go to 0, and all register-file entries clear to 0.
  - Reset overrides flush, stall and write-back, including when it arrives mid-operation.
- Latency: ID/EX register is loaded on every rising edge; ID-to-EX latency is 1 cycle.
- Decode (instruction bits [31:21], or the prefixes listed):
  - LDUR 7C2: MemRead=1, Mem2Reg=1, ALUSrc=1, RegWrite=1, ALUOp=0010, imm = sext [20:12].
  - STUR 7C0: MemWrite=1, ALUSrc=1, ALUOp=0010, imm = sext [20:12], B reads Rt.
  - ADD 458: RegWrite=1, ALUOp=0010.
  - SUB 658: RegWrite=1, ALUOp=0110.
  - AND 450: RegWrite=1, ALUOp=0000.
  - ORR 550: RegWrite=1, ALUOp=0001.
  - CBZ, [31:24]=B4: Branch=1, ALUOp=0111, imm = sext [23:5], B reads Rt.
  - B, [31:26]=05: Uncondbranch=1, imm = sext [25:0].
  - Don't-care fields are driven 0. Immediates are unshifted.
- Unknown opcode: all controls 0 and illegal_EX=1 when valid_id=1.
- Register read fields: Rn = [9:5]; Rm = [20:16]; Rt = [4:0] for STUR/CBZ.
- Register file:
  - Written on the rising edge when regwrite_wb=1, rd_wb is not NREG-1 and resetl=0.
  - Reads are combinational.
  - Bypass: if regwrite_wb=1, rd_wb equals the read index, and that index is not XZR, the read returns wbdata in the same cycle.
- Load-use hazard (combinational):
  - stall_id = valid_ex & MemRead_EX & (RD_EX != NREG-1) & valid_id & (RD_EX == Rn, or RD_EX == the B-read register when the instruction reads B).
  - When stall_id=1: the next EX contents are a bubble (all controls, illegal_EX and valid_ex = 0). Data fields are don't-care and are driven 0.
  - The upstream stage holds the instruction, so it re-decodes next cycle.
- Flush: when flush=1, the next EX contents are a bubble regardless of stall. stall_id is forced to 0 during flush.
- valid_id=0: the next EX contents are a bubble.
- Priority: resetl > flush > stall > normal.
- Indices ≥ NREG read 0 and write nothing.

Optional Feature:
- Macro ID_STALL_CNT_EN.
  - Defined: adds output stall_cnt [31:0]. It increments on every edge where stall_id=1 and resetl=0, clears on reset, and saturates at FFFFFFFF.
  - Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then LDUR 32'hF84003E9 with pc_id=4 and valid_id=1 -> next edge: MemRead=1, Mem2Reg=1, ALUSrc=1, RegWrite=1, ALUOp=0010, RD_EX=9, SignExtImm=0, pc_EX=4, valid_ex=1.
2. Write X9=64'h1234 via WB while ORR X10,X9,XZR (32'hAA1F012A) is in ID -> bypass gives RegOutA_EX=0x1234, RegOutB_EX=0, ALUOp=0001, RD_EX=10.
3. LDUR X9 followed by ADD X11,X9,X2 -> stall_id=1 for exactly one cycle; EX gets a bubble (valid_ex=0, RegWrite_EX=0); ADD reaches EX one cycle later.
4. Assert flush together with a hazard -> stall_id=0, EX bubble, illegal_EX=0; a write with rd_wb=31, wbdata=FF reads back 0.
5. CBZ with imm19=7FFFF -> SignExtImm64_EX = all ones, Branch=1, ALUOp=0111. Opcode 32'h0 -> illegal_EX=1, all controls 0.
6. Assert resetl mid-stream with valid outputs -> all outputs 0 on the next edge and registers read 0. With ID_STALL_CNT_EN, stall_cnt returns to 0.
